// File: rtl/iir_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed IIR filter.
package iir_pkg;

  // Sample-processing sequence: accept, run all taps, drain the multiplier,
  // scale/saturate, then present the result.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    FLUSH = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits (order 1 still needs a wire).
  function automatic int addr_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // Accumulator width: one product plus growth for n terms plus one guard bit.
  function automatic int acc_width(input int w, input int cw, input int n);
    return w + cw + clog2(n) + 1;
  endfunction

  // Clip a signed value to a w-bit signed range. The result is {sat_flag, value},
  // with the value sign-extended to 64 bits; callers keep the low w bits.
  // Supports sums up to 64 bits, which covers every legal parameter set.
  function automatic logic [64:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return {1'b1, hi};
    if (v < lo) return {1'b1, lo};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/iir_filter_mac_if.sv
// Sample stream, result and coefficient-programming signals of iir_filter_mac.
//
// Handshake: a sample is transferred on a rising clock edge where i_valid and
// o_ready are both high. o_ready is high only while the filter is idle; i_valid
// seen while o_ready is low is dropped, never queued. o_valid is a single-cycle
// pulse marking a fresh o_filter/o_sat; there is no backpressure on the output.
interface iir_filter_mac_if
  import iir_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int COEF_W  = 16,
  parameter int N_ORDER = 4,
  parameter int AW      = addr_width(N_ORDER)
);
  logic                     i_valid;
  logic                     o_ready;
  logic signed [WIDTH-1:0]  i_filter;
  logic                     o_valid;
  logic signed [WIDTH-1:0]  o_filter;
  logic                     o_sat;
  logic                     i_clear;
  logic                     i_coef_wr;
  logic                     i_coef_sel;
  logic [AW-1:0]            i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic                     i_coef_commit;
  logic                     o_coef_pending;
  state_t                   dbg_state;

  modport master (
    output i_valid, i_filter, i_clear, i_coef_wr, i_coef_sel, i_coef_addr,
           i_coef_data, i_coef_commit,
    input  o_ready, o_valid, o_filter, o_sat, o_coef_pending, dbg_state
  );

  modport slave (
    input  i_valid, i_filter, i_clear, i_coef_wr, i_coef_sel, i_coef_addr,
           i_coef_data, i_coef_commit,
    output o_ready, o_valid, o_filter, o_sat, o_coef_pending, dbg_state
  );
endinterface

// File: rtl/iir_coef_bank.sv
// Double-buffered a/b coefficient store: shadow bank written at any time,
// active bank loaded from shadow on the first idle cycle after a commit.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int N_ORDER = 4,
  parameter int COEF_W  = 16,
  parameter int AW      = addr_width(N_ORDER)
) (
  input  logic                     i_clkp,
  input  logic                     i_rstn,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     commit,
  input  logic                     idle,
  input  logic                     rd_sel,
  input  logic [AW-1:0]            rd_idx,
  output logic signed [COEF_W-1:0] rd_coef,
  output logic                     pending
);
  logic signed [COEF_W-1:0] shadow_b [N_ORDER];
  logic signed [COEF_W-1:0] shadow_a [N_ORDER];
  logic signed [COEF_W-1:0] active_b [N_ORDER];
  logic signed [COEF_W-1:0] active_a [N_ORDER];
  logic                     pending_q;
  logic                     copy;

  // Copy only between samples so a running computation never sees a mixed set.
  assign copy = idle && pending_q;

  // Shadow bank write port; addresses beyond the order are ignored.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      for (int i = 0; i < N_ORDER; i++) begin
        shadow_b[i] <= '0;
        shadow_a[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < N_ORDER)) begin
      if (wr_sel) shadow_a[wr_addr] <= wr_data;
      else        shadow_b[wr_addr] <= wr_data;
    end
  end

  // Active bank load; a same-cycle shadow write lands after this copy.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      for (int i = 0; i < N_ORDER; i++) begin
        active_b[i] <= '0;
        active_a[i] <= '0;
      end
    end else if (copy) begin
      for (int i = 0; i < N_ORDER; i++) begin
        active_b[i] <= shadow_b[i];
        active_a[i] <= shadow_a[i];
      end
    end
  end

  // Pending flag; a commit coinciding with the copy re-arms it.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn)     pending_q <= 1'b0;
    else if (commit) pending_q <= 1'b1;
    else if (copy)   pending_q <= 1'b0;
  end

  assign pending = pending_q;
  assign rd_coef = rd_sel ? active_a[rd_idx] : active_b[rd_idx];

endmodule

// File: rtl/iir_filter_mac.sv
// Direct-form-I IIR filter sharing one signed multiplier across all taps.
// b taps (x history) are issued first, then a taps (y history); each product is
// registered once before landing in its own accumulator.
module iir_filter_mac
  import iir_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_ORDER = 4,
  parameter int COEF_W  = 16,
  parameter int FRAC_B  = 14,
  parameter int FRAC_A  = 14
) (
  input logic            i_clkp,
  input logic            i_rstn,
  iir_filter_mac_if.slave bus
);
  localparam int AW     = addr_width(N_ORDER);
  localparam int CW     = addr_width(2 * N_ORDER);
  localparam int ACC_W  = acc_width(WIDTH, COEF_W, N_ORDER);
  localparam int PROD_W = WIDTH + COEF_W;
  localparam logic [CW-1:0] LAST_TAP = CW'(2 * N_ORDER - 1);
  localparam logic [CW-1:0] N_TAPS   = CW'(N_ORDER);

  state_t                   state, state_nxt;
  logic [CW-1:0]            tap_cnt;
  logic                     tap_is_a;
  logic [AW-1:0]            tap_idx;
  logic signed [COEF_W-1:0] tap_coef;
  logic signed [WIDTH-1:0]  tap_sample;
  logic signed [PROD_W-1:0] coef_ext, sample_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_vld, prod_is_a;
  logic signed [ACC_W-1:0]  acc_b, acc_a;
  logic signed [ACC_W:0]    sum;
  logic [64:0]              sat_res;
  logic signed [WIDTH-1:0]  y_reg;
  logic                     sat_reg;
  logic signed [WIDTH-1:0]  x_hist [N_ORDER];
  logic signed [WIDTH-1:0]  y_hist [N_ORDER];
  logic                     is_idle, accept;

  assign is_idle = (state == IDLE);
  assign accept  = is_idle && bus.i_valid && !bus.i_clear;

  // State register.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; clear aborts from any state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_valid) state_nxt = MAC;
      MAC:     if (tap_cnt == LAST_TAP) state_nxt = FLUSH;
      FLUSH:   state_nxt = SCALE;
      SCALE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.i_clear) state_nxt = IDLE;
  end

  // Tap counter: runs 0..2N-1 during MAC, parked at zero otherwise.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn || bus.i_clear || state != MAC) tap_cnt <= '0;
    else                                        tap_cnt <= tap_cnt + 1'b1;
  end

  // Tap decode: first N counts address b/x, the rest address a/y.
  assign tap_is_a   = (tap_cnt >= N_TAPS);
  assign tap_idx    = tap_is_a ? AW'(tap_cnt - N_TAPS) : AW'(tap_cnt);
  assign tap_sample = tap_is_a ? y_hist[tap_idx] : x_hist[tap_idx];
  assign coef_ext   = PROD_W'(tap_coef);
  assign sample_ext = PROD_W'(tap_sample);

  iir_coef_bank #(
    .N_ORDER (N_ORDER),
    .COEF_W  (COEF_W)
  ) u_coef_bank (
    .i_clkp  (i_clkp),
    .i_rstn  (i_rstn),
    .wr_en   (bus.i_coef_wr),
    .wr_sel  (bus.i_coef_sel),
    .wr_addr (bus.i_coef_addr),
    .wr_data (bus.i_coef_data),
    .commit  (bus.i_coef_commit),
    .idle    (is_idle),
    .rd_sel  (tap_is_a),
    .rd_idx  (tap_idx),
    .rd_coef (tap_coef),
    .pending (bus.o_coef_pending)
  );

  // Shared multiplier with a one-cycle output register.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn || bus.i_clear) begin
      prod      <= '0;
      prod_vld  <= 1'b0;
      prod_is_a <= 1'b0;
    end else begin
      prod      <= coef_ext * sample_ext;
      prod_vld  <= (state == MAC);
      prod_is_a <= tap_is_a;
    end
  end

  // Separate b and a accumulators so each gets its own fractional shift.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn || bus.i_clear || accept) begin
      acc_b <= '0;
      acc_a <= '0;
    end else if (prod_vld) begin
      if (prod_is_a) acc_a <= acc_a + ACC_W'(prod);
      else           acc_b <= acc_b + ACC_W'(prod);
    end
  end

  // Scale both sums (floor shift), add and clip to the output range.
  always_comb begin
    sum     = (ACC_W + 1)'(acc_b >>> FRAC_B) + (ACC_W + 1)'(acc_a >>> FRAC_A);
    sat_res = sat_to_width(64'(sum), WIDTH);
  end

  // Result register: loaded in SCALE; clear drops the flag but keeps the value.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      y_reg   <= '0;
      sat_reg <= 1'b0;
    end else if (bus.i_clear) begin
      sat_reg <= 1'b0;
    end else if (state == SCALE) begin
      y_reg   <= WIDTH'(sat_res[63:0]);
      sat_reg <= sat_res[64];
    end
  end

  // Sample histories: x shifts on accept, y shifts in the saturated result at DONE.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn || bus.i_clear) begin
      for (int i = 0; i < N_ORDER; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_hist[0] <= bus.i_filter;
        for (int i = 1; i < N_ORDER; i++) x_hist[i] <= x_hist[i-1];
      end
      if (state == DONE) begin
        y_hist[0] <= y_reg;
        for (int i = 1; i < N_ORDER; i++) y_hist[i] <= y_hist[i-1];
      end
    end
  end

  assign bus.o_ready   = is_idle;
  assign bus.o_valid   = (state == DONE);
  assign bus.o_filter  = y_reg;
  assign bus.o_sat     = sat_reg;
  assign bus.dbg_state = state;

endmodule

// File: doc/iir_filter_mac.md
Name: iir_filter_mac

Overview:
Parametrised, time-multiplexed direct-form-I IIR filter for the trap-frequency stabilisation loop. One signed multiplier is shared across all taps, and samples move through a valid/ready handshake. Coefficients are double-buffered so they can be rewritten at runtime without glitching. Output is saturated, and an overflow flag is reported with each sample.

Parameters:
WIDTH, 16, signed sample width of input and output.
N_ORDER, 4, filter order (1..16); number of b taps and number of a taps.
COEF_W, 16, signed coefficient width.
FRAC_B, 14, fractional bits of b coefficients (Q(COEF_W-FRAC_B).FRAC_B).
FRAC_A, 14, fractional bits of a coefficients.

Ports:
i_clkp  in  1  clock
i_rstn  in  1  reset, synchronous, active-low
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample (high only in IDLE)
i_filter  in  WIDTH  signed input sample x[n]
o_valid  out  1  one-cycle pulse: o_filter holds a new y[n]
o_filter  out  WIDTH  signed output y[n], held until the next o_valid
o_sat  out  1  y[n] was clipped; qualified by o_valid
i_clear  in  1  flush histories/accumulators, abort computation
i_coef_wr  in  1  write one shadow coefficient
i_coef_sel  in  1  0 = b bank, 1 = a bank
i_coef_addr  in  clog2(N_ORDER)  tap index k (b: 0..N-1, a: maps to a_(k+1))
i_coef_data  in  COEF_W  signed coefficient
i_coef_commit  in  1  request shadow-to-active copy
o_coef_pending  out  1  commit requested, not yet applied

Behaviour:
- Equation: y[n] = sat( (sum_{k=0..N-1} b_k*x[n-k]) >>> FRAC_B + (sum_{k=1..N} a_k*y[n-k]) >>> FRAC_A ).
  - >>> is an arithmetic shift (floor).
  - The y history holds the saturated outputs.
- Accumulators: two of them, each ACC_W = WIDTH+COEF_W+clog2(N_ORDER)+1 bits, so they cannot overflow.
- Saturation: the shifted sum is clipped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; o_sat=1 when clipping occurred.
- FSM: IDLE -> MAC -> FLUSH -> SCALE -> DONE -> IDLE.
  - IDLE: o_ready=1. On i_valid, x history shifts in i_filter and the state goes to MAC.
  - MAC: 2*N_ORDER cycles. b taps are issued first, then a taps; the product is registered one cycle.
  - FLUSH: 1 cycle; accumulates the last product.
  - SCALE: 1 cycle; shift, add, saturate; result registers into o_filter/o_sat.
  - DONE: o_valid=1 for exactly one cycle, and the y history shifts in o_filter.
- Timing: accept at cycle T gives o_valid at T+2*N_ORDER+3 (N=4: T+11).
  - o_ready is low T+1..T+2N+3 and high again at T+2N+4.
  - Throughput is one sample per 2N+4 cycles.
- i_valid while o_ready=0 is ignored; it is not queued.
- Reset values: o_valid=0, o_filter=0, o_sat=0, o_ready=1 (state IDLE), o_coef_pending=0. Histories, accumulators and both coefficient banks are zero.
- Reset mid-operation: the computation is discarded and no o_valid is produced.
- i_clear, any state: next cycle is IDLE.
  - Histories and accumulators zeroed; o_valid and o_sat = 0.
  - Coefficients, o_filter and o_coef_pending are retained.
  - Dominates i_valid in the same cycle.
- Coefficient writes: i_coef_wr writes the shadow bank only, in any state.
- Commit: i_coef_commit sets pending.
  - The copy to the active bank happens at the end of the first cycle with state==IDLE and pending=1, then pending clears.
  - A sample accepted in that same cycle uses the new set.
  - A computation in progress always completes with the old set.
  - A shadow write in the same cycle as the copy is not included in that copy.
  - A commit arriving in the same cycle as the copy re-arms pending.

Decomposition:
- Package iir_pkg holds:
  - the state enum (IDLE, MAC, FLUSH, SCALE, DONE);
  - a clog2 function;
  - an acc-width function;
  - a saturate-to-WIDTH function returning {sat_flag, value}.
- One sub-module, iir_coef_bank: shadow and active register files for a and b, write port, pending flag, and a tap-select read mux driven by the FSM tap counter.

Test Plan:
- Timing, N=4: b0=0x4000 (1.0), others 0; x=1000 accepted at T -> o_valid only at T+11, o_filter=1000; o_ready low T+1..T+11; i_valid pulses during busy are ignored.
- Feedback: b0=0x4000, a1=0x2000 (0.5), impulse x=1000 then zeros -> y=1000,500,250,125,62,31,15,7,3,1,0. Then x=-1 with a=0 gives y=-1 (floor shift check).
- Saturation: b0=0x7FFF; x=30000 -> y=32767, o_sat=1; x=-30000 -> y=-32768, o_sat=1; x=100 -> y=199, o_sat=0.
- Commit: with b0=0x4000, accept x=800, write b0=0x2000 and commit during MAC -> output 800 and pending=1 until IDLE. Next x=800 -> 400 and pending=0.
- Clear/reset: impulse into the a1=0x2000 filter; assert i_clear mid-MAC of sample 3 -> no o_valid, o_ready=1 next cycle. Next x=0 -> y=0 with coefficients intact. Then assert i_rstn=0 mid-MAC -> all outputs 0 and coefficients zero.
